// File: rtl/bcd_disp_conv.sv
// Sign-magnitude to sign + 3-digit BCD converter for the 7-segment driver.
// Uses a sequential double-dabble engine, triggered by a refresh tick or START.
module bcd_disp_conv #(
    parameter int SAMPLE_DIV = 1000000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [9:0] DIN,
    input  logic       START,
    output logic       BUSY,
    output logic       DONE,
    output logic       SIGN,
    output logic [3:0] BCD2,
    output logic [3:0] BCD1,
    output logic [3:0] BCD0,
    output logic [2:0] BLANK
);
    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] tick_cnt;
    logic          tick, trig;
    logic [21:0]   sr, sr_nxt, adj;
    logic [3:0]    bit_cnt, bit_cnt_nxt;
    logic          sign_cap;
    logic          cap, upd;
    logic [9:0]    mag10;

    assign tick  = (tick_cnt == CW'(SAMPLE_DIV - 1));
    assign trig  = tick | START;
    // -512 arrives as sign set with zero magnitude
    assign mag10 = (DIN[8:0] == 9'd0 && DIN[9]) ? 10'd512 : {1'b0, DIN[8:0]};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) tick_cnt <= '0;
        else        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end

    // add-3 correction on each BCD nibble ahead of the shift
    assign adj[9:0] = sr[9:0];
    for (genvar g = 0; g < 3; g++) begin : g_nib
        logic [3:0] nib;
        assign nib                = sr[10+4*g +: 4];
        assign adj[10+4*g +: 4]   = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end

    always_comb begin
        state_nxt   = state;
        sr_nxt      = sr;
        bit_cnt_nxt = bit_cnt;
        cap         = 1'b0;
        upd         = 1'b0;
        case (state)
            IDLE: begin
                if (trig) begin
                    cap         = 1'b1;
                    sr_nxt      = {12'b0, mag10};
                    bit_cnt_nxt = 4'd9;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                sr_nxt = adj << 1;
                if (bit_cnt == 4'd0) state_nxt = UPDATE;
                else                 bit_cnt_nxt = bit_cnt - 4'd1;
            end
            UPDATE: begin
                upd       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            sr       <= '0;
            bit_cnt  <= '0;
            sign_cap <= 1'b0;
        end else begin
            state   <= state_nxt;
            sr      <= sr_nxt;
            bit_cnt <= bit_cnt_nxt;
            if (cap) sign_cap <= DIN[9];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            SIGN  <= 1'b0;
            BCD2  <= 4'd0;
            BCD1  <= 4'd0;
            BCD0  <= 4'd0;
            BLANK <= 3'b110;
        end else begin
            BUSY <= (state_nxt != IDLE);
            DONE <= upd;
            if (upd) begin
                SIGN  <= sign_cap;
                BCD2  <= sr[21:18];
                BCD1  <= sr[17:14];
                BCD0  <= sr[13:10];
                BLANK <= {sr[21:18] == 4'd0, sr[21:14] == 8'd0, 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_bcd_disp_conv.sv
// Directed bench for bcd_disp_conv with a 16-cycle refresh period.
module tb_bcd_disp_conv;
    logic       CLK = 1'b0;
    logic       RST_N;
    logic [9:0] DIN;
    logic       START;
    logic       BUSY, DONE, SIGN;
    logic [3:0] BCD2, BCD1, BCD0;
    logic [2:0] BLANK;
    logic [3:0] tb_cnt;

    int checks   = 0;
    int failures = 0;

    bcd_disp_conv #(.SAMPLE_DIV(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .START(START),
        .BUSY(BUSY), .DONE(DONE), .SIGN(SIGN),
        .BCD2(BCD2), .BCD1(BCD1), .BCD0(BCD0), .BLANK(BLANK)
    );

    always #5 CLK = ~CLK;

    // refresh phase: value the DUT counter holds ahead of the next edge
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) tb_cnt <= 4'd0;
        else        tb_cnt <= (tb_cnt == 4'd15) ? 4'd0 : tb_cnt + 4'd1;
    end

    function automatic logic [15:0] outs();
        return {SIGN, BCD2, BCD1, BCD0, BLANK};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // posedges until DONE is seen at a negedge; -1 on timeout
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 64; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (DONE) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic conv(input string tag, input logic [9:0] din, input logic [15:0] exp);
        int n;
        wait_done(n);
        chk({tag, "_sync"}, n > 0, 1);
        DIN   = din;
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        chk({tag, "_busy"}, BUSY, 1);
        wait_done(n);
        chk({tag, "_lat"}, n, 11);
        chk({tag, "_out"}, outs(), exp);
        chk({tag, "_idle"}, BUSY, 0);
    endtask

    initial begin
        int n, dn, at;
        logic [15:0] first;
        logic ok;

        RST_N = 1'b0;
        DIN   = 10'h000;
        START = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_out", outs(), 16'h0006);
        RST_N = 1'b1;

        // free-running refresh with zero input
        wait_done(n);
        chk("tick_first", n, 27);
        chk("tick_out", outs(), {1'b0, 4'd0, 4'd0, 4'd0, 3'b110});
        wait_done(n);
        chk("tick_period", n, 16);

        conv("max",    10'h1FF, {1'b0, 4'd5, 4'd1, 4'd1, 3'b000});
        conv("neg123", 10'h27B, {1'b1, 4'd1, 4'd2, 4'd3, 3'b000});
        conv("neg512", 10'h200, {1'b1, 4'd5, 4'd1, 4'd2, 3'b000});
        conv("seven",  10'h007, {1'b0, 4'd0, 4'd0, 4'd7, 3'b110});
        conv("fortytwo", 10'h02A, {1'b0, 4'd0, 4'd4, 4'd2, 3'b100});
        conv("x256",   10'h100, {1'b0, 4'd2, 4'd5, 4'd6, 3'b000});

        // retrigger and DIN change during a conversion are ignored
        wait_done(n);
        chk("rt_sync", n > 0, 1);
        DIN   = 10'h0C8;
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1 begin START = 1'b1; DIN = 10'h063; end
        @(posedge CLK);
        #1 START = 1'b0;
        dn = 0; at = 0; first = '0;
        for (int i = 4; i <= 16; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (DONE) begin
                dn++;
                if (dn == 1) begin at = i; first = outs(); end
            end
        end
        chk("rt_count", dn, 1);
        chk("rt_lat", at, 11);
        chk("rt_out", first, {1'b0, 4'd2, 4'd0, 4'd0, 3'b000});
        DIN = 10'h0C8;

        // START on the same edge as the refresh tick
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            if (tb_cnt == 4'd15 && !BUSY) begin ok = 1'b1; break; end
        end
        chk("co_sync", ok, 1);
        DIN   = 10'h3E7;
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        dn = 0; at = 0; first = '0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (DONE) begin
                dn++;
                if (dn == 1) begin at = i; first = outs(); end
            end
        end
        chk("co_count", dn, 1);
        chk("co_lat", at, 11);
        chk("co_out", first, {1'b1, 4'd4, 4'd8, 4'd7, 3'b000});

        // reset in the middle of a conversion
        wait_done(n);
        chk("mr_sync", n > 0, 1);
        DIN   = 10'h1FF;
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (5) @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("mr_busy", BUSY, 0);
        chk("mr_done", DONE, 0);
        chk("mr_out", outs(), 16'h0006);
        @(negedge CLK);
        @(negedge CLK);
        chk("mr_hold", outs(), 16'h0006);
        RST_N = 1'b1;
        wait_done(n);
        chk("mr_restart", n, 27);
        chk("mr_after", outs(), {1'b0, 4'd5, 4'd1, 4'd1, 3'b000});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
